bird_io_bridge: RTL and testbench
=================================

// Module: bird_io_bridge
// PURPOSE
//  Memory/IO bridge directly downstream of the bird CPU bus (address, data_out, memwt, data_in).
//  Decodes each CPU access to 4K-word RAM or memory-mapped I/O: RX byte FIFO, TX byte FIFO,
//  status register, prescaled 16-bit timer. Returns read data combinationally, same cycle,
//  because the CPU samples data_in in the state that drives the address.
// PARAMETERS
//  RX_DEPTH  4      RX FIFO entries (power of 2, >=2)
//  TX_DEPTH  4      TX FIFO entries (power of 2, >=2)
//  PRESCALE  50000  clk cycles per timer increment (>=1)
// PORTS
//  clk          in   1   system clock, all state on posedge
//  rst          in   1   synchronous reset, active-high, priority over all other events
//  cpu_address  in   16  CPU bus address
//  cpu_wdata    in   16  CPU write data (CPU data_out)
//  cpu_memwt    in   1   CPU write strobe, one cycle per write
//  cpu_rdata    out  16  read data to CPU data_in (combinational)
//  mem_address  out  12  RAM address = cpu_address[11:0]
//  mem_wdata    out  16  RAM write data = cpu_wdata
//  mem_we       out  1   RAM write enable
//  mem_rdata    in   16  RAM asynchronous read data
//  rx_strobe    in   1   one-cycle pulse: rx_byte valid, no backpressure
//  rx_byte      in   8   incoming byte
//  tx_valid     out  1   TX FIFO non-empty
//  tx_byte      out  8   TX FIFO head
//  tx_ready     in   1   consumer accepts head when tx_valid&&tx_ready
// BEHAVIOUR
//  Map: 0x0000-0x0FFF RAM; 0xF000 STATUS; 0xF001 RXDATA; 0xF002 TXDATA; 0xF003 TIMER; else unmapped.
//  mem_we = cpu_memwt && RAM hit. Unmapped: reads 0x0000, writes ignored.
//  cpu_rdata: RAM->mem_rdata; STATUS->{12'b0,tmr_wrap,tx_drop,rx_ovf,rx_nempty};
//   RXDATA->{8'b0,rx head} or 0x0000 if empty; TXDATA->{12'b0,tx count}; TIMER->counter.
//  RX pop: edge ending any cycle with address==0xF001, !cpu_memwt, RX non-empty (no read strobe
//   exists; software must not execute code from 0xF001). Pop on empty: no change.
//  RX push on rx_strobe: accepted if not full; if full and no pop same cycle, drop byte, set rx_ovf.
//   Full + strobe + pop same cycle: both occur, count unchanged, no overflow.
//  TX push on cpu_memwt to 0xF002, byte = cpu_wdata[7:0]; if full and no pop same cycle, drop,
//   set tx_drop. Empty + push: tx_valid rises next cycle (1-cycle latency), no bypass.
//  Pointers wrap modulo depth; occupancy counter 0..DEPTH distinguishes full/empty.
//  Write to STATUS: bits written 1 clear matching sticky bits rx_ovf[1], tx_drop[2], tmr_wrap[3];
//   a set event in the same cycle wins over the clear.
//  Timer: prescaler counts 0..PRESCALE-1; at terminal count counter+=1, prescaler->0.
//   0xFFFF->0x0000 sets tmr_wrap. Write to TIMER loads cpu_wdata, prescaler->0 (write beats increment).
//  Reset: FIFOs empty, pointers/counts 0, sticky bits 0, timer 0, prescaler 0;
//   tx_valid=0, tx_byte=0x00; FIFO contents discarded mid-operation. Comb outputs follow inputs.
// TESTING
//  RAM: write 0x1234 to 0x0005 -> mem_we=1, mem_address=0x005; read 0x0005 -> cpu_rdata=mem_rdata.
//  RX: 5 strobes 0x41..0x45, depth 4 -> STATUS=0x0003; reads of 0xF001 give 0x41..0x44, then 0x0000.
//  TX: 4 writes with tx_ready=0, 5th write -> STATUS bit2=1, TXDATA=4; tx_ready=1 drains in order.
//  Simultaneous: RX full, strobe+read 0xF001 same cycle -> head returned, count stays 4, rx_ovf=0.
//  Timer, PRESCALE=2: load 0xFFFE -> 0xFFFF after 2 clk, 0x0000 after 4 clk, STATUS bit3=1; write 0x0008 to STATUS clears it.
//  Reset mid-TX with 3 queued -> next cycle tx_valid=0, STATUS=0x0000, TIMER=0x0000.

Source files
------------

// File: rtl/bird_bus_if.sv
// bird CPU bus bundle: address, write data, write strobe, read data.
// The CPU drives the request side; the bridge returns data the same cycle.
interface bird_bus_if;
  logic [15:0] cpu_address;
  logic [15:0] cpu_wdata;
  logic        cpu_memwt;
  logic [15:0] cpu_rdata;

  modport master (
    output cpu_address,
    output cpu_wdata,
    output cpu_memwt,
    input  cpu_rdata
  );

  modport slave (
    input  cpu_address,
    input  cpu_wdata,
    input  cpu_memwt,
    output cpu_rdata
  );
endinterface

// File: rtl/bird_io_bridge.sv
// Memory/IO bridge for the bird CPU: 4K-word RAM window plus
// RX/TX byte FIFOs, sticky status bits and a prescaled 16-bit timer.
module bird_io_bridge #(
  parameter int RX_DEPTH = 4,
  parameter int TX_DEPTH = 4,
  parameter int PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        rst,
  bird_bus_if.slave   bus,
  output logic [11:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  input  logic        rx_strobe,
  input  logic [7:0]  rx_byte,
  output logic        tx_valid,
  output logic [7:0]  tx_byte,
  input  logic        tx_ready
);
  localparam int RXA = $clog2(RX_DEPTH);
  localparam int TXA = $clog2(TX_DEPTH);
  localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [RXA:0]  RX_FULL = (RXA+1)'(RX_DEPTH);
  localparam logic [TXA:0]  TX_FULL = (TXA+1)'(TX_DEPTH);
  localparam logic [PW-1:0] PS_MAX  = PW'(PRESCALE - 1);

  logic [7:0]     rx_mem_q [RX_DEPTH];
  logic [RXA-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [RXA:0]   rx_cnt_q, rx_cnt_d;
  logic [7:0]     tx_mem_q [TX_DEPTH];
  logic [TXA-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [TXA:0]   tx_cnt_q, tx_cnt_d;
  logic           rx_ovf_q, rx_ovf_d;
  logic           tx_drop_q, tx_drop_d;
  logic           tmr_wrap_q, tmr_wrap_d;
  logic [15:0]    tmr_q, tmr_d;
  logic [PW-1:0]  pre_q, pre_d;

  logic ram_hit, st_hit, rxd_hit, txd_hit, tmr_hit;
  logic rx_full, rx_nempty, rx_pop, rx_push, rx_ovf_set;
  logic tx_full, tx_pop, tx_req, tx_push, tx_drop_set;
  logic st_wr, tmr_wr, tmr_tc, tmr_wrap_set;

  assign ram_hit = bus.cpu_address[15:12] == 4'h0;
  assign st_hit  = bus.cpu_address == 16'hF000;
  assign rxd_hit = bus.cpu_address == 16'hF001;
  assign txd_hit = bus.cpu_address == 16'hF002;
  assign tmr_hit = bus.cpu_address == 16'hF003;

  assign mem_address = bus.cpu_address[11:0];
  assign mem_wdata   = bus.cpu_wdata;
  assign mem_we      = bus.cpu_memwt && ram_hit;

  // A read of RXDATA consumes the head; a full FIFO can still
  // accept a byte when it is popped in the same cycle.
  assign rx_full    = rx_cnt_q == RX_FULL;
  assign rx_nempty  = rx_cnt_q != '0;
  assign rx_pop     = rxd_hit && !bus.cpu_memwt && rx_nempty;
  assign rx_push    = rx_strobe && (!rx_full || rx_pop);
  assign rx_ovf_set = rx_strobe && rx_full && !rx_pop;

  assign tx_full     = tx_cnt_q == TX_FULL;
  assign tx_valid    = tx_cnt_q != '0;
  assign tx_byte     = tx_valid ? tx_mem_q[tx_rp_q] : 8'h00;
  assign tx_pop      = tx_valid && tx_ready;
  assign tx_req      = bus.cpu_memwt && txd_hit;
  assign tx_push     = tx_req && (!tx_full || tx_pop);
  assign tx_drop_set = tx_req && tx_full && !tx_pop;

  assign st_wr        = bus.cpu_memwt && st_hit;
  assign tmr_wr       = bus.cpu_memwt && tmr_hit;
  assign tmr_tc       = pre_q == PS_MAX;
  assign tmr_wrap_set = !tmr_wr && tmr_tc && (tmr_q == 16'hFFFF);

  // Read mux returned to the CPU in the same cycle.
  always_comb begin
    bus.cpu_rdata = 16'h0000;
    unique case (1'b1)
      ram_hit: bus.cpu_rdata = mem_rdata;
      st_hit:  bus.cpu_rdata = {12'h000, tmr_wrap_q, tx_drop_q,
                                rx_ovf_q, rx_nempty};
      rxd_hit: bus.cpu_rdata = rx_nempty ?
                 {8'h00, rx_mem_q[rx_rp_q]} : 16'h0000;
      txd_hit: bus.cpu_rdata = 16'(tx_cnt_q);
      tmr_hit: bus.cpu_rdata = tmr_q;
      default: bus.cpu_rdata = 16'h0000;
    endcase
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    rx_wp_d  = rx_wp_q;
    rx_rp_d  = rx_rp_q;
    rx_cnt_d = rx_cnt_q;
    tx_wp_d  = tx_wp_q;
    tx_rp_d  = tx_rp_q;
    tx_cnt_d = tx_cnt_q;
    if (rx_push) rx_wp_d = rx_wp_q + 1'b1;
    if (rx_pop)  rx_rp_d = rx_rp_q + 1'b1;
    if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + 1'b1;
    if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - 1'b1;
    if (tx_push) tx_wp_d = tx_wp_q + 1'b1;
    if (tx_pop)  tx_rp_d = tx_rp_q + 1'b1;
    if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + 1'b1;
    if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - 1'b1;
  end

  // Sticky status and timer next-state; set events beat clears.
  always_comb begin
    rx_ovf_d   = (rx_ovf_q && !(st_wr && bus.cpu_wdata[1]))
                 || rx_ovf_set;
    tx_drop_d  = (tx_drop_q && !(st_wr && bus.cpu_wdata[2]))
                 || tx_drop_set;
    tmr_wrap_d = (tmr_wrap_q && !(st_wr && bus.cpu_wdata[3]))
                 || tmr_wrap_set;
    tmr_d = tmr_q;
    pre_d = pre_q + 1'b1;
    if (tmr_wr) begin
      tmr_d = bus.cpu_wdata;
      pre_d = '0;
    end else if (tmr_tc) begin
      tmr_d = tmr_q + 16'h0001;
      pre_d = '0;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates them.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_byte;
    if (tx_push) tx_mem_q[tx_wp_q] <= bus.cpu_wdata[7:0];
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_cnt_q   <= '0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      rx_ovf_q   <= 1'b0;
      tx_drop_q  <= 1'b0;
      tmr_wrap_q <= 1'b0;
      tmr_q      <= 16'h0000;
      pre_q      <= '0;
    end else begin
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_ovf_q   <= rx_ovf_d;
      tx_drop_q  <= tx_drop_d;
      tmr_wrap_q <= tmr_wrap_d;
      tmr_q      <= tmr_d;
      pre_q      <= pre_d;
    end
  end
endmodule

// File: tb/tb_bird_io_bridge.sv
// Bench for bird_io_bridge: directed scenarios then random traffic,
// all compared against a queue-based model of the memory map.
module tb_bird_io_bridge;
  localparam int RXD = 4;
  localparam int TXD = 4;
  localparam int PS  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic        rx_strobe;
  logic [7:0]  rx_byte;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_ready;

  always #5 clk = ~clk;

  bird_bus_if bus ();

  bird_io_bridge #(
    .RX_DEPTH(RXD), .TX_DEPTH(TXD), .PRESCALE(PS)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata),
    .rx_strobe(rx_strobe), .rx_byte(rx_byte),
    .tx_valid(tx_valid), .tx_byte(tx_byte),
    .tx_ready(tx_ready)
  );

  // Reference model state
  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  logic        m_ovf, m_drop, m_wrap;
  logic [15:0] m_tmr;
  int          m_ticks;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_rd(input logic [15:0] a,
                                         input logic [15:0] mr);
    if (a < 16'h1000) return mr;
    case (a)
      16'hF000: return {12'h000, m_wrap, m_drop, m_ovf, rxq.size() != 0};
      16'hF001: return (rxq.size() != 0) ? {8'h00, rxq[0]} : 16'h0000;
      16'hF002: return 16'(txq.size());
      16'hF003: return m_tmr;
      default:  return 16'h0000;
    endcase
  endfunction

  task automatic model_clear();
    rxq.delete();
    txq.delete();
    m_ovf = 0; m_drop = 0; m_wrap = 0;
    m_tmr = 16'h0000; m_ticks = 0;
  endtask

  task automatic model_step(input logic [15:0] a, input logic [15:0] wd,
                            input bit we, input bit rs,
                            input logic [7:0] rb, input bit tr);
    bit pop_rx, pop_tx, ovf_s, drop_s, wrap_s;
    pop_rx = (a == 16'hF001) && !we && (rxq.size() > 0);
    pop_tx = (txq.size() > 0) && tr;
    ovf_s = 0; drop_s = 0; wrap_s = 0;
    if (pop_rx) void'(rxq.pop_front());
    if (pop_tx) void'(txq.pop_front());
    if (rs) begin
      if (rxq.size() < RXD) rxq.push_back(rb);
      else ovf_s = 1;
    end
    if (we && a == 16'hF002) begin
      if (txq.size() < TXD) txq.push_back(wd[7:0]);
      else drop_s = 1;
    end
    if (we && a == 16'hF003) begin
      m_tmr = wd;
      m_ticks = 0;
    end else begin
      m_ticks++;
      if (m_ticks == PS) begin
        m_ticks = 0;
        if (m_tmr == 16'hFFFF) wrap_s = 1;
        m_tmr = m_tmr + 16'h0001;
      end
    end
    if (we && a == 16'hF000) begin
      if (wd[1]) m_ovf = 0;
      if (wd[2]) m_drop = 0;
      if (wd[3]) m_wrap = 0;
    end
    m_ovf  = m_ovf  | ovf_s;
    m_drop = m_drop | drop_s;
    m_wrap = m_wrap | wrap_s;
  endtask

  // One bus cycle: drive at negedge, check comb outputs, advance model.
  task automatic cyc(input logic [15:0] a, input logic [15:0] wd,
                     input bit we, input bit rs, input logic [7:0] rb,
                     input bit tr, output logic [15:0] rd,
                     output logic txv);
    logic [15:0] exp_tb;
    @(negedge clk);
    rst = 1'b0;
    bus.cpu_address = a;
    bus.cpu_wdata   = wd;
    bus.cpu_memwt   = we;
    rx_strobe = rs;
    rx_byte   = rb;
    tx_ready  = tr;
    mem_rdata = 16'($urandom);
    #1;
    rd  = bus.cpu_rdata;
    txv = tx_valid;
    chk("rdata", bus.cpu_rdata, exp_rd(a, mem_rdata));
    chk("mem_we", {15'h0, mem_we}, {15'h0, we && (a < 16'h1000)});
    chk("mem_addr", {4'h0, mem_address}, {4'h0, a[11:0]});
    chk("mem_wdata", mem_wdata, wd);
    chk("tx_valid", {15'h0, tx_valid}, {15'h0, txq.size() != 0});
    exp_tb = (txq.size() != 0) ? {8'h00, txq[0]} : 16'h0000;
    chk("tx_byte", {8'h00, tx_byte}, exp_tb);
    @(posedge clk);
    model_step(a, wd, we, rs, rb, tr);
  endtask

  // Reset cycle with busy inputs: reset must win over all of them.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.cpu_address = 16'hF002;
    bus.cpu_wdata   = 16'h00EE;
    bus.cpu_memwt   = 1'b1;
    rx_strobe = 1'b1;
    rx_byte   = 8'hEE;
    tx_ready  = 1'b0;
    @(posedge clk);
    model_clear();
  endtask

  logic [15:0] rd;
  logic        txv;

  initial begin
    rst = 1'b1;
    bus.cpu_address = 16'h0000;
    bus.cpu_wdata   = 16'h0000;
    bus.cpu_memwt   = 1'b0;
    rx_strobe = 1'b0;
    rx_byte   = 8'h00;
    tx_ready  = 1'b0;
    mem_rdata = 16'h0000;
    model_clear();
    do_reset();

    // Reset state
    cyc(16'hF000, 0, 0, 0, 0, 0, rd, txv);
    chk("reset_status", rd, 16'h0000);
    chk("reset_txv", {15'h0, txv}, 16'h0000);

    // RAM write and read
    cyc(16'h0005, 16'h1234, 1, 0, 0, 0, rd, txv);
    cyc(16'h0005, 16'h0000, 0, 0, 0, 0, rd, txv);

    // RX overflow and drain
    for (int i = 0; i < 5; i++)
      cyc(16'h0100, 0, 0, 1, 8'(8'h41 + i), 0, rd, txv);
    cyc(16'hF000, 0, 0, 0, 0, 0, rd, txv);
    chk("rx_status", rd, 16'h0003);
    for (int i = 0; i < 5; i++) begin
      cyc(16'hF001, 0, 0, 0, 0, 0, rd, txv);
      chk("rx_read", rd, (i < 4) ? 16'(16'h41 + i) : 16'h0000);
    end
    cyc(16'hF000, 16'h0002, 1, 0, 0, 0, rd, txv);

    // TX overflow and drain
    for (int i = 0; i < 5; i++)
      cyc(16'hF002, 16'(16'h10 + i), 1, 0, 0, 0, rd, txv);
    cyc(16'hF000, 0, 0, 0, 0, 0, rd, txv);
    chk("tx_drop_bit", {15'h0, rd[2]}, 16'h0001);
    cyc(16'hF002, 0, 0, 0, 0, 0, rd, txv);
    chk("tx_count", rd, 16'h0004);
    for (int i = 0; i < 5; i++)
      cyc(16'h0200, 0, 0, 0, 0, 1, rd, txv);
    chk("tx_drained", {15'h0, txv}, 16'h0000);
    cyc(16'hF000, 16'h0004, 1, 0, 0, 0, rd, txv);

    // RX full with strobe and pop together
    for (int i = 0; i < 4; i++)
      cyc(16'h0100, 0, 0, 1, 8'(8'hA0 + i), 0, rd, txv);
    cyc(16'hF001, 0, 0, 1, 8'h99, 0, rd, txv);
    chk("simul_head", rd, 16'h00A0);
    cyc(16'hF000, 0, 0, 0, 0, 0, rd, txv);
    chk("simul_status", rd, 16'h0001);
    for (int i = 0; i < 5; i++) begin
      cyc(16'hF001, 0, 0, 0, 0, 0, rd, txv);
      chk("simul_read", rd,
          (i < 3) ? 16'(16'hA1 + i) : (i == 3) ? 16'h0099 : 16'h0000);
    end

    // Timer wrap
    cyc(16'hF003, 16'hFFFE, 1, 0, 0, 0, rd, txv);
    cyc(16'hF003, 0, 0, 0, 0, 0, rd, txv);
    chk("tmr_0", rd, 16'hFFFE);
    cyc(16'hF003, 0, 0, 0, 0, 0, rd, txv);
    chk("tmr_1", rd, 16'hFFFE);
    cyc(16'hF003, 0, 0, 0, 0, 0, rd, txv);
    chk("tmr_2", rd, 16'hFFFF);
    cyc(16'hF003, 0, 0, 0, 0, 0, rd, txv);
    cyc(16'hF003, 0, 0, 0, 0, 0, rd, txv);
    chk("tmr_4", rd, 16'h0000);
    cyc(16'hF000, 0, 0, 0, 0, 0, rd, txv);
    chk("tmr_wrap", rd, 16'h0008);
    cyc(16'hF000, 16'h0008, 1, 0, 0, 0, rd, txv);
    cyc(16'hF000, 0, 0, 0, 0, 0, rd, txv);
    chk("tmr_wrap_clr", rd, 16'h0000);

    // Reset with TX traffic queued
    for (int i = 0; i < 3; i++)
      cyc(16'hF002, 16'(16'h30 + i), 1, 0, 0, 0, rd, txv);
    do_reset();
    cyc(16'hF000, 0, 0, 0, 0, 0, rd, txv);
    chk("rst_status", rd, 16'h0000);
    chk("rst_txv", {15'h0, txv}, 16'h0000);
    cyc(16'hF003, 0, 0, 0, 0, 0, rd, txv);
    chk("rst_tmr", rd, 16'h0000);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    a = 16'($urandom_range(0, 16'h0FFF));
        2:       a = 16'hF000;
        3, 4:    a = 16'hF001;
        5, 6:    a = 16'hF002;
        7:       a = 16'hF003;
        8:       a = 16'(16'hF004 + $urandom_range(0, 16'h0FFB));
        default: a = 16'($urandom);
      endcase
      cyc(a, 16'($urandom), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) == 0), 8'($urandom),
          ($urandom_range(0, 1) == 1), rd, txv);
      if (i % 1000 == 999) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
